// File: rtl/counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// counter_bank_pkg
// Shared definitions for the counter bank controller:
//   - ev_t      : per-cycle resolved event applied to every channel
//   - *_DEF     : default parameter values used by counter_bank_ctrl and
//                 debounce_pulse
//   - ev_resolve: priority/merge of the three event sources into one event
// -----------------------------------------------------------------------------
package counter_bank_pkg;

    // Default parameter values
    localparam int NUM_CH_DEF          = 16;
    localparam int WIDTH_DEF           = 16;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int TICK_DIV_DEF        = 100_000_000;
    localparam int SATURATE_DEF        = 0;

    // Resolved event applied to the whole bank in a given cycle
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_INC  = 2'd1,
        EV_DEC  = 2'd2,
        EV_CLR  = 2'd3
    } ev_t;

    // Clear wins over everything; simultaneous increment and decrement cancel.
    function automatic ev_t ev_resolve(
        input logic clr_p,
        input logic inc_p,
        input logic dec_p
    );
        ev_t ev;
        if (clr_p) begin
            ev = EV_CLR;
        end else if (inc_p && dec_p) begin
            ev = EV_NONE;
        end else if (inc_p) begin
            ev = EV_INC;
        end else if (dec_p) begin
            ev = EV_DEC;
        end else begin
            ev = EV_NONE;
        end
        return ev;
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
// Conditions one raw asynchronous push button:
//   2-flop synchroniser -> level debouncer -> one-cycle press pulse.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronised
// samples that differ from the currently accepted level; any sample equal to
// the accepted level restarts the count. Only an accepted 0->1 transition
// produces a pulse; releases are silent.
//
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset (deassertion already
//                 synchronised by the parent)
//   btn    in  1  raw button level
//   press  out 1  registered one-cycle pulse on an accepted press
// -----------------------------------------------------------------------------
module debounce_pulse
    import counter_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    // DEBOUNCE_CYCLES >= 2, so the counter is at least one bit wide and only
    // has to reach DEBOUNCE_CYCLES-1.
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_r;
    logic          sync_s;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;

    assign sync_s = sync_r[1];
    assign press  = press_r;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    // Debounce counter, accepted level and press pulse.
    // The sample that completes the window updates the level and raises the
    // pulse in the same edge, so the pulse lags the synchronised input by
    // exactly DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b0;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else if (sync_s == stable_r) begin
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= sync_s;
            cnt_r    <= '0;
            press_r  <= sync_s;
        end else begin
            cnt_r    <= cnt_r + CW'(1);
            press_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_bank_ctrl.sv
// -----------------------------------------------------------------------------
// counter_bank_ctrl
// Bank of NUM_CH WIDTH-bit counters driven in lock-step by three debounced
// buttons (increment, decrement, clear) and an optional periodic auto-tick.
//
// Pipeline for a button event:
//   sync (2) -> debounce (DEBOUNCE_CYCLES) -> ev_r register (1) -> counters (1)
// giving a constant button-to-counter latency of DEBOUNCE_CYCLES + 4 cycles.
// The update pulse follows the counter change by one cycle and is raised only
// when at least one channel value actually changed.
//
// Ports:
//   clk       in  1             system clock
//   reset_n   in  1             asynchronous active-low reset
//   btn_inc   in  1             raw increment button
//   btn_dec   in  1             raw decrement button
//   btn_clr   in  1             raw clear button
//   auto_en   in  1             synchronous enable for periodic auto-increment
//   data_raw  out NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   ovf       out NUM_CH        sticky per-channel wrap/saturation flag
//   update    out 1             one-cycle pulse after any data_raw change
// -----------------------------------------------------------------------------
module counter_bank_ctrl
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH          = NUM_CH_DEF,
    parameter int WIDTH           = WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF,
    parameter int SATURATE        = SATURATE_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    btn_inc,
    input  logic                    btn_dec,
    input  logic                    btn_clr,
    input  logic                    auto_en,
    output logic [NUM_CH*WIDTH-1:0] data_raw,
    output logic [NUM_CH-1:0]       ovf,
    output logic                    update
);

    localparam int              DW       = $clog2(TICK_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Reset conditioning: assertion is immediate, deassertion is aligned
    // to clk so no flop sees reset release near an active edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_r;
    logic       rst_n;

    // Reset release synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_r[1];

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic inc_p;
    logic dec_p;
    logic clr_p;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_inc),
        .press (inc_p)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_dec),
        .press (dec_p)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clr),
        .press (clr_p)
    );

    // ------------------------------------------------------------------
    // Auto-tick divider
    // ------------------------------------------------------------------
    logic [DW-1:0] div_r;
    logic          tick_s;

    // Divider counts only while enabled and restarts from zero when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
        end else if (!auto_en) begin
            div_r <= '0;
        end else if (div_r == DIV_LAST) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    // Gated by auto_en so a disable on the terminal count suppresses the tick.
    assign tick_s = auto_en && (div_r == DIV_LAST);

    // ------------------------------------------------------------------
    // Event resolution
    // ------------------------------------------------------------------
    ev_t ev_r;

    // Registered resolved event shared by every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_r <= EV_NONE;
        end else begin
            ev_r <= ev_resolve(clr_p, inc_p | tick_s, dec_p);
        end
    end

    // ------------------------------------------------------------------
    // Counter bank
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] chg_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Clear/reset value is the channel index truncated to WIDTH bits.
        localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(i);

        logic [WIDTH-1:0] cnt_r;
        logic [WIDTH-1:0] nxt_s;
        logic             ovf_r;
        logic             ovf_nxt_s;
        logic             chg_r;

        // Next value and overflow flag for this channel.
        always_comb begin
            nxt_s     = cnt_r;
            ovf_nxt_s = ovf_r;
            case (ev_r)
                EV_CLR: begin
                    nxt_s     = INIT_VAL;
                    ovf_nxt_s = 1'b0;
                end
                EV_INC: begin
                    if (cnt_r == MAX_VAL) begin
                        ovf_nxt_s = 1'b1;
                        if (SATURATE != 0) begin
                            nxt_s = cnt_r;
                        end else begin
                            nxt_s = '0;
                        end
                    end else begin
                        nxt_s = cnt_r + WIDTH'(1);
                    end
                end
                EV_DEC: begin
                    if (cnt_r == '0) begin
                        ovf_nxt_s = 1'b1;
                        if (SATURATE != 0) begin
                            nxt_s = cnt_r;
                        end else begin
                            nxt_s = MAX_VAL;
                        end
                    end else begin
                        nxt_s = cnt_r - WIDTH'(1);
                    end
                end
                EV_NONE: begin
                    nxt_s     = cnt_r;
                    ovf_nxt_s = ovf_r;
                end
                default: begin
                    nxt_s     = cnt_r;
                    ovf_nxt_s = ovf_r;
                end
            endcase
        end

        // Channel state plus a change marker that feeds the update pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= INIT_VAL;
                ovf_r <= 1'b0;
                chg_r <= 1'b0;
            end else begin
                cnt_r <= nxt_s;
                ovf_r <= ovf_nxt_s;
                chg_r <= (nxt_s != cnt_r);
            end
        end

        assign data_raw[i*WIDTH +: WIDTH] = cnt_r;
        assign ovf[i]                     = ovf_r;
        assign chg_s[i]                   = chg_r;
    end

    // ------------------------------------------------------------------
    // Update pulse
    // ------------------------------------------------------------------
    logic update_r;

    // One cycle after any channel value moved; ovf-only changes do not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_r <= 1'b0;
        end else begin
            update_r <= |chg_s;
        end
    end

    assign update = update_r;

endmodule

// File: tb/tb_counter_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_bank_ctrl
// Two instances (wrap and saturate) share all stimulus. A table of button
// presses with hand-computed expected banks is applied in a loop; latency,
// glitch rejection, auto-tick and reset-during-debounce are hand sequences.
// -----------------------------------------------------------------------------
module tb_counter_bank_ctrl;

    localparam int NCH = 4;
    localparam int W   = 4;
    localparam int DB  = 4;
    localparam int TD  = 8;

    localparam int OP_INC = 0;
    localparam int OP_DEC = 1;
    localparam int OP_CLR = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           btn_inc;
    logic           btn_dec;
    logic           btn_clr;
    logic           auto_en;
    logic [NCH*W-1:0] data0;
    logic [NCH*W-1:0] data1;
    logic [NCH-1:0] ovf0;
    logic [NCH-1:0] ovf1;
    logic           upd0;
    logic           upd1;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt0 = 0;
    int upd_cnt1 = 0;

    always #5 clk = ~clk;

    counter_bank_ctrl #(
        .NUM_CH(NCH), .WIDTH(W), .DEBOUNCE_CYCLES(DB), .TICK_DIV(TD), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_clr(btn_clr), .auto_en(auto_en), .data_raw(data0), .ovf(ovf0),
        .update(upd0)
    );

    counter_bank_ctrl #(
        .NUM_CH(NCH), .WIDTH(W), .DEBOUNCE_CYCLES(DB), .TICK_DIV(TD), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_clr(btn_clr), .auto_en(auto_en), .data_raw(data1), .ovf(ovf1),
        .update(upd1)
    );

    // Count update pulses of both instances, sampled on the falling edge.
    always @(negedge clk) begin
        if (upd0) upd_cnt0 <= upd_cnt0 + 1;
        if (upd1) upd_cnt1 <= upd_cnt1 + 1;
    end

    typedef struct {
        int          op;
        int          reps;
        logic [15:0] d0;
        logic [3:0]  o0;
        logic [15:0] d1;
        logic [3:0]  o1;
        int          u0;
        int          u1;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        btn_clr = 1'b0;
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input int op, input int hold, input int gap);
        @(negedge clk);
        case (op)
            OP_INC:  btn_inc = 1'b1;
            OP_DEC:  btn_dec = 1'b1;
            default: btn_clr = 1'b1;
        endcase
        repeat (hold) @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        btn_clr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int u0s;
        int u1s;

        reset_n = 1'b0;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        btn_clr = 1'b0;
        auto_en = 1'b0;

        //             op      reps d0        o0     d1        o1     u0  u1
        vecs[0] = '{OP_INC, 12, 16'hFEDC, 4'h0, 16'hFEDC, 4'h0, 12, 12};
        vecs[1] = '{OP_INC,  1, 16'h0FED, 4'h8, 16'hFFED, 4'h8,  1,  1};
        vecs[2] = '{OP_INC,  1, 16'h10FE, 4'hC, 16'hFFFE, 4'hC,  1,  1};
        vecs[3] = '{OP_CLR,  1, 16'h3210, 4'h0, 16'h3210, 4'h0,  1,  1};
        vecs[4] = '{OP_CLR,  1, 16'h3210, 4'h0, 16'h3210, 4'h0,  0,  0};
        vecs[5] = '{OP_DEC,  1, 16'h210F, 4'h1, 16'h2100, 4'h1,  1,  1};
        vecs[6] = '{OP_DEC,  1, 16'h10FE, 4'h3, 16'h1000, 4'h3,  1,  1};
        vecs[7] = '{OP_INC,  1, 16'h210F, 4'h3, 16'h2111, 4'h3,  1,  1};
        vecs[8] = '{OP_CLR,  1, 16'h3210, 4'h0, 16'h3210, 4'h0,  1,  1};

        // Reset state
        do_reset();
        check("rst_data_wrap", data0, 16'h3210);
        check("rst_data_sat",  data1, 16'h3210);
        check("rst_ovf_wrap",  ovf0,  4'h0);
        check("rst_ovf_sat",   ovf1,  4'h0);
        check("rst_upd_wrap",  upd0,  1'b0);
        check("rst_upd_sat",   upd1,  1'b0);

        // Glitch shorter than the debounce window is ignored
        u0s = upd_cnt0;
        press(OP_INC, 3, 8);
        check("glitch_data", data0, 16'h3210);
        check("glitch_upd",  upd_cnt0 - u0s, 0);

        // Clean press: counter moves on edge 8, update on edge 9 only
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("lat_edge7_data", data0, 16'h3210);
        @(posedge clk);
        #1;
        check("lat_edge8_data", data0, 16'h4321);
        check("lat_edge8_upd",  upd0,  1'b0);
        @(posedge clk);
        #1;
        check("lat_edge9_upd",  upd0,  1'b1);
        @(posedge clk);
        #1;
        check("lat_edge10_upd", upd0,  1'b0);
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        check("hold_data_wrap", data0, 16'h4321);
        check("hold_data_sat",  data1, 16'h4321);
        check("hold_upd_cnt",   upd_cnt0 - u0s, 1);

        // Table-driven press sequence from reset state
        do_reset();
        for (int r = 0; r < 9; r++) begin
            u0s = upd_cnt0;
            u1s = upd_cnt1;
            for (int k = 0; k < vecs[r].reps; k++) begin
                press(vecs[r].op, 10, 10);
            end
            check($sformatf("vec%0d_data_wrap", r), data0, vecs[r].d0);
            check($sformatf("vec%0d_ovf_wrap",  r), ovf0,  vecs[r].o0);
            check($sformatf("vec%0d_data_sat",  r), data1, vecs[r].d1);
            check($sformatf("vec%0d_ovf_sat",   r), ovf1,  vecs[r].o1);
            check($sformatf("vec%0d_upd_wrap",  r), upd_cnt0 - u0s, vecs[r].u0);
            check($sformatf("vec%0d_upd_sat",   r), upd_cnt1 - u1s, vecs[r].u1);
        end

        // Auto-tick: 24 enabled cycles give three increments
        do_reset();
        u0s = upd_cnt0;
        @(negedge clk);
        auto_en = 1'b1;
        repeat (24) @(negedge clk);
        auto_en = 1'b0;
        repeat (4) @(negedge clk);
        check("tick_data_wrap", data0, 16'h6543);
        check("tick_data_sat",  data1, 16'h6543);
        check("tick_upd_cnt",   upd_cnt0 - u0s, 3);

        // Tick coincident with a decrement press cancels out
        u0s = upd_cnt0;
        @(negedge clk);
        auto_en = 1'b1;
        @(negedge clk);
        btn_dec = 1'b1;
        repeat (7) @(negedge clk);
        auto_en = 1'b0;
        repeat (6) @(negedge clk);
        btn_dec = 1'b0;
        repeat (12) @(negedge clk);
        check("coinc_data_wrap", data0, 16'h6543);
        check("coinc_data_sat",  data1, 16'h6543);
        check("coinc_upd_cnt",   upd_cnt0 - u0s, 0);

        // Reset during the second debounce cycle of a held clear
        @(negedge clk);
        btn_clr = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_data_async", data0, 16'h3210);
        check("midrst_ovf_async",  ovf0,  4'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        u0s = upd_cnt0;
        u1s = upd_cnt1;
        repeat (20) @(negedge clk);
        btn_clr = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_data_wrap", data0, 16'h3210);
        check("midrst_data_sat",  data1, 16'h3210);
        check("midrst_upd_wrap",  upd_cnt0 - u0s, 0);
        check("midrst_upd_sat",   upd_cnt1 - u1s, 0);
        u0s = upd_cnt0;
        press(OP_INC, 10, 10);
        check("postrst_inc_data", data0, 16'h4321);
        check("postrst_inc_upd",  upd_cnt0 - u0s, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_bank_ctrl.md
COUNTER_BANK_CTRL -- requirements
Module: counter_bank_ctrl

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_CH, default 16: number of counter channels (1..64).
REQ-003 Parameter WIDTH, default 16: bits per channel counter (2..32).
REQ-004 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required before a button is accepted (>=2).
REQ-005 Parameter TICK_DIV, default 100_000_000: clk cycles per auto-tick (>=2).
REQ-006 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-007 clk  input  1  system clock, 100 MHz.
REQ-008 reset_n  input  1  asynchronous active-low reset.
REQ-009 btn_inc  input  1  raw asynchronous increment button.
REQ-010 btn_dec  input  1  raw asynchronous decrement button.
REQ-011 btn_clr  input  1  raw asynchronous clear button.
REQ-012 auto_en  input  1  synchronous enable for periodic auto-increment.
REQ-013 data_raw  output  NUM_CH*WIDTH  channel i counter at bits [i*WIDTH +: WIDTH].
REQ-014 ovf  output  NUM_CH  sticky per-channel limit flag.
REQ-015 update  output  1  one-cycle pulse, high the cycle after any data_raw change.

Function
REQ-016 Each button SHALL pass a 2-flop synchroniser, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal synchronised samples; any change restarts the count.
REQ-017 Each debouncer SHALL emit a one-cycle press pulse on an accepted 0->1 transition only; releases emit nothing; holding emits one pulse.
REQ-018 Tick divider SHALL count 0..TICK_DIV-1 while auto_en=1, pulse tick on the terminal count, and clear to 0 within one cycle of auto_en=0.
REQ-019 Event resolution per cycle: clr pulse -> clear; else inc = inc pulse OR tick; inc and dec both active -> no change; inc only -> +1; dec only -> -1.
REQ-020 Clear SHALL load channel i with value i mod 2^WIDTH and zero all ovf bits.
REQ-021 +1/-1 SHALL apply to all channels in the same cycle, computed at WIDTH bits.
REQ-022 SATURATE=0: max+1 -> 0 and 0-1 -> max, setting that channel's ovf.
REQ-023 SATURATE=1: a channel at max ignores +1, at 0 ignores -1, and sets its ovf when blocked.
REQ-024 ovf bits SHALL stay set until clear or reset.
REQ-025 Counters SHALL change one cycle after the resolved event pulse; update pulses one cycle after the counter change, only if at least one channel value changed.
REQ-026 Button-to-counter latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 2 cycles, constant per event.

Reset
REQ-027 On reset_n low, channel i SHALL load value i mod 2^WIDTH, ovf = 0, update = 0, divider = 0, synchronisers and debouncers = 0 (released).
REQ-028 Reset asserted mid-debounce or mid-tick SHALL discard the pending event; no pulse after deassertion unless a button is still held through a full debounce window.
REQ-029 Deassertion SHALL be synchronised to clk inside the block before reaching sequential logic.

Structure
REQ-030 Shared package counter_bank_pkg SHALL hold event-encoding constants (EV_NONE, EV_INC, EV_DEC, EV_CLR) and the default parameter values.
REQ-031 One sub-module debounce_pulse (synchroniser + debouncer + rising-edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times.
REQ-032 Counter bank SHALL be a generate loop over NUM_CH; no inter-channel logic beyond the shared event.

Verification (NUM_CH=4, WIDTH=4, DEBOUNCE_CYCLES=4, TICK_DIV=8 unless stated)
REQ-033 Reset release -> data_raw = {4'd3,4'd2,4'd1,4'd0}, ovf=0, update=0.
REQ-034 btn_inc glitch high 3 cycles, then clean press held 20 cycles -> exactly one +1 to {4,3,2,1}; update single pulse; latency 8 cycles.
REQ-035 SATURATE=0, 13 inc presses from reset -> channel 3 wraps to 0 and ovf[3]=1, channel 0 = 13, ovf[0]=0; then clr press -> {3,2,1,0}, ovf=0.
REQ-036 SATURATE=1, dec press from reset -> channel 0 stays 0 with ovf[0]=1, others decrement to {2,1,0}.
REQ-037 auto_en=1 for 24 cycles -> three increments; tick coincident with dec press -> no change, no update pulse.
REQ-038 reset_n low during 2nd debounce cycle of held btn_clr, released while still held -> values at reset state, clear accepted once after full window, update pulses only if a value changed.
